mem_refill_unit: RTL
====================

MEM_REFILL_UNIT -- requirements
Module: mem_refill_unit

Interface
REQ-001 Parameters SHALL be:
- LINE_BYTES, default 16, bytes per cache line (power of 2, 4..32).
- MEM_ADDR_BITS, default 12, byte-address width of the backing store.
- READ_LATENCY, default 4, idle cycles before the first refill beat (1..15).

REQ-002 Ports SHALL be:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  cache miss or write-through request.
- req_ready  output  1  unit can accept a request.
- req_addr  input  32  byte address.
- req_is_write  input  1  1 = byte write-through, 0 = line refill.
- req_wdata  input  8  write byte.
- fill_valid  output  1  refilled line available.
- fill_ready  input  1  cache accepts the line.
- fill_addr  output  32  line base address: req_addr with the low log2(LINE_BYTES) bits cleared.
- fill_data  output  8*LINE_BYTES  line bytes; byte k is at bits [8k+7:8k].
- wr_done  output  1  one-cycle pulse when a write completes.
- refill_count  output  16  completed refills, saturating.

Function
REQ-003 The backing store SHALL be MEM_ADDR_BITS-addressed bytes indexed by req_addr[MEM_ADDR_BITS-1:0]; upper address bits SHALL be ignored (aliasing).
REQ-004 Initial store contents SHALL be mem[i] = i[7:0] ^ 8'hA5; rst SHALL NOT alter store contents.
REQ-005 The FSM SHALL have exactly the states IDLE, WAIT, BURST, RESP and WRITE; req_ready SHALL be 1 only in IDLE.
REQ-006 A request SHALL be accepted only on a clock edge where req_valid=1 and req_ready=1.
- At acceptance, req_addr, req_is_write and req_wdata SHALL be captured.
- Later changes to these inputs SHALL have no effect on the accepted request.
REQ-007 On a read acceptance, the FSM SHALL go IDLE->WAIT and load a latency counter; WAIT SHALL last exactly READ_LATENCY cycles, then the FSM SHALL go to BURST.
REQ-008 BURST SHALL last exactly LINE_BYTES cycles.
- Beat k SHALL read store byte (line base + k) into fill_data byte k, for k = 0..LINE_BYTES-1.
- The beat counter SHALL wrap to 0 on leaving BURST.
- Line base indexing SHALL wrap modulo 2^MEM_ADDR_BITS.
REQ-009 After the last beat, the FSM SHALL enter RESP with fill_valid=1.
- fill_addr and fill_data SHALL hold stable while fill_valid=1.
- On a cycle with fill_valid=1 and fill_ready=1, the FSM SHALL return to IDLE with fill_valid=0 on the next cycle.
REQ-010 Read latency SHALL be: acceptance edge to first fill_valid=1 cycle = 1 + READ_LATENCY + LINE_BYTES cycles (21 with defaults).
REQ-011 If fill_ready=1 is already high on entry to RESP, the line SHALL be handed over in that first RESP cycle (fill_valid high for one cycle).
REQ-012 On a write acceptance, the FSM SHALL go IDLE->WRITE.
- In WRITE the store byte at the captured address SHALL be written with the captured req_wdata.
- wr_done SHALL pulse for that single cycle.
- The next state SHALL be IDLE.
- fill_valid SHALL stay 0 for the whole write.
REQ-013 A write that follows a refill SHALL be visible to every later refill of the same line; no data caching is done inside the unit.
REQ-014 refill_count SHALL increment by 1 on each completed fill handshake and SHALL saturate at 16'hFFFF.
REQ-015 A req_valid pulse while req_ready=0 SHALL be ignored; no queueing is done.

Reset
REQ-016 While rst=1 at a clock edge, the unit SHALL go to IDLE with the following outputs on the next cycle:
- req_ready=1
- fill_valid=0
- wr_done=0
- fill_addr=0
- fill_data=0
- refill_count=0
REQ-017 rst asserted during WAIT, BURST, RESP or WRITE SHALL abort the operation.
- No fill_valid or wr_done SHALL be produced for the aborted request.
- A WRITE aborted in its single cycle SHALL NOT modify the store.
- rst SHALL take priority over a simultaneous req_valid.

Verification
REQ-018 Read refill: req_addr=32'h02001F81, read -> after 21 cycles fill_valid=1, fill_addr=32'h02001F80, fill_data byte0=8'h25 (0xF80^0xA5 low byte), byte1=8'h24; refill_count=1.
REQ-019 Write then refill: write req_addr=32'h02001F71 with data 8'h09 -> wr_done pulses once; then read 32'h02001F71 -> fill_addr=32'h02001F70, fill_data byte1=8'h09, byte0=8'hD5.
REQ-020 Backpressure: hold fill_ready=0 for 10 cycles in RESP -> fill_valid stays 1, data stable, req_ready=0; a req_valid pulse then is ignored; after fill_ready=1, one handover occurs and req_ready=1 on the next cycle.
REQ-021 Reset mid-burst: assert rst in BURST beat 5 -> next cycle req_ready=1, fill_valid=0, refill_count unchanged at 0; a new read completes normally.
REQ-022 Wrap: read req_addr=32'h00000FF5 -> fill_addr=32'h00000FF0, bytes from 0xFF0..0xFFF; with LINE_BYTES=32, base 0xFE0 reads 0xFE0..0xFFF, no overrun.
REQ-023 Saturation: force 65536 refills (or preload counter in sim) -> refill_count stops at 16'hFFFF.

Source files
------------

// File: rtl/mem_refill_unit.sv
// mem_refill_unit: services cache line refills and byte write-throughs
// against a small byte-addressed backing store. A refill waits a fixed
// read latency, streams one byte per cycle into a line buffer, then holds
// the line until the cache takes it. Writes update the store in one cycle.
module mem_refill_unit #(
  parameter int LINE_BYTES    = 16,
  parameter int MEM_ADDR_BITS = 12,
  parameter int READ_LATENCY  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    req_is_write,
  input  logic [7:0]              req_wdata,
  output logic                    fill_valid,
  input  logic                    fill_ready,
  output logic [31:0]             fill_addr,
  output logic [8*LINE_BYTES-1:0] fill_data,
  output logic                    wr_done,
  output logic [15:0]             refill_count
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int AW    = MEM_ADDR_BITS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    BURST = 3'd2,
    RESP  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // The store is kept XOR-coded against its power-up pattern
  // (addr[7:0] ^ 8'hA5), so an all-zero array means "never written"
  // and no content-loading logic is needed.
  logic [7:0] store_x [DEPTH] = '{default: 8'h00};

  logic [AW-1:0]           mem_idx;
  logic [7:0]              wdata_cap;
  logic [3:0]              lat_cnt;
  logic [OFF_W-1:0]        beat_cnt;
  logic [31:0]             fill_addr_q;
  logic [8*LINE_BYTES-1:0] fill_data_q;
  logic [15:0]             cnt_q;
  logic [AW-1:0]           rd_idx;
  logic [7:0]              rd_byte;
  logic                    accept;

  // Saturating increment for the refill counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decode a store byte back to its real value.
  function automatic logic [7:0] store_decode(input logic [7:0] x, input logic [AW-1:0] a);
    logic [7:0] a8;
    a8 = 8'(a);
    return x ^ a8 ^ 8'hA5;
  endfunction

  assign accept  = (state == IDLE) && req_valid;
  // Line base plus beat offset wraps naturally within the store width.
  assign rd_idx  = mem_idx + AW'(beat_cnt);
  assign rd_byte = store_decode(store_x[rd_idx], rd_idx);

  assign fill_addr    = fill_addr_q;
  assign fill_data    = fill_data_q;
  assign refill_count = cnt_q;

  // State register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_is_write ? WRITE : WAIT;
      WAIT:    if (lat_cnt == 4'd1) state_nxt = BURST;
      BURST:   if (beat_cnt == OFF_W'(LINE_BYTES - 1)) state_nxt = RESP;
      RESP:    if (fill_ready) state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; a reset cycle suppresses completion strobes so an
  // aborted request never reports a fill or a write.
  always_comb begin
    req_ready  = 1'b0;
    fill_valid = 1'b0;
    wr_done    = 1'b0;
    case (state)
      IDLE:    req_ready  = 1'b1;
      RESP:    fill_valid = !rst;
      WRITE:   wr_done    = !rst;
      default: ;
    endcase
  end

  // Request capture: reads keep the line base index, writes the byte index.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_idx   <= req_is_write ? req_addr[AW-1:0]
                                : {req_addr[AW-1:OFF_W], {OFF_W{1'b0}}};
      wdata_cap <= req_wdata;
    end
  end

  // Latency and beat counters, line buffer and refill counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt     <= '0;
      beat_cnt    <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_cnt  <= 4'(READ_LATENCY);
            beat_cnt <= '0;
            if (!req_is_write)
              fill_addr_q <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
          end
        end
        WAIT:  lat_cnt <= lat_cnt - 4'd1;
        BURST: begin
          fill_data_q[{beat_cnt, 3'b000} +: 8] <= rd_byte;
          beat_cnt <= beat_cnt + 1'b1;
        end
        RESP:  if (fill_ready) cnt_q <= sat_inc16(cnt_q);
        default: ;
      endcase
    end
  end

  // Store write port; a write cut short by reset leaves the store alone.
  always_ff @(posedge clk) begin
    if (state == WRITE && !rst)
      store_x[mem_idx] <= wdata_cap ^ 8'(mem_idx) ^ 8'hA5;
  end

endmodule
